// File: rtl/riscv_pkg.sv
// Shared RV32 encodings used by the load/store path: opcodes, ALU ops,
// decoder store-size / load-type codes and the LSU state type.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_SB   = 2'd1;
  localparam logic [1:0] ST_SH   = 2'd2;
  localparam logic [1:0] ST_SW   = 2'd3;

  localparam logic [2:0] LD_LW  = 3'd1;
  localparam logic [2:0] LD_LB  = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_t;

  // Unknown load codes behave as LW, so they need full word alignment.
  function automatic logic lsu_misaligned(input logic       store,
                                          input logic [1:0] size,
                                          input logic [2:0] ltype,
                                          input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (store) begin
      case (size)
        ST_SH:   bad = off[0];
        ST_SW:   bad = (off != 2'b00);
        default: bad = 1'b0;
      endcase
    end else begin
      case (ltype)
        LD_LB, LD_LBU: bad = 1'b0;
        LD_LH, LD_LHU: bad = off[0];
        default:       bad = (off != 2'b00);
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store byte enables / lane replication and
// load byte/halfword extraction with sign or zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  st_size,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_type,
  input  logic [31:0] rdata,
  output logic [3:0]  be_st,
  output logic [31:0] wdata_rep,
  output logic [31:0] ld_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be_st     = 4'b0000;
    wdata_rep = 32'h0;
    case (st_size)
      ST_SB: begin
        be_st     = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      ST_SH: begin
        be_st     = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
      end
      ST_SW: begin
        be_st     = 4'b1111;
        wdata_rep = wdata;
      end
      default: ;
    endcase
  end

  // Halfword loads are only issued when off[0]=0, so off[1] picks the half.
  always_comb begin
    byte_sel = 8'h0;
    case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: ;
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_type)
      LD_LB:   ld_ext = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  ld_ext = {24'h0, byte_sel};
      LD_LH:   ld_ext = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  ld_ext = {16'h0, half_sel};
      default: ld_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit front end: captures a decoded access, runs the handshaked
// data-memory transaction with a timeout, and stalls the core until it ends.
module lsu_mem_if
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_start,
  input  logic        is_store,
  input  logic [1:0]  st_size,
  input  logic [2:0]  ld_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        err_misalign,
  output logic        err_timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_t       state;
  logic             cap_store;
  logic [2:0]       cap_ld;
  logic [1:0]       cap_off;
  logic [CNT_W-1:0] cnt;

  logic             idle;
  logic             timed_out;
  logic [1:0]       a_off;
  logic [2:0]       a_ld;
  logic [3:0]       be_st;
  logic [31:0]      wdata_rep;
  logic [31:0]      ld_ext;

  assign idle      = (state == S_IDLE);
  assign timed_out = (cnt >= CNT_W'(TIMEOUT_CYC - 1));
  assign stall     = (idle && lsu_start) || (state == S_REQ) || (state == S_WAIT);

  // Live inputs steer lanes while launching; captured ones steer the returned data.
  assign a_off = idle ? addr[1:0] : cap_off;
  assign a_ld  = idle ? ld_type   : cap_ld;

  lsu_align u_align (
    .off       (a_off),
    .st_size   (st_size),
    .wdata     (wdata),
    .ld_type   (a_ld),
    .rdata     (mem_rdata),
    .be_st     (be_st),
    .wdata_rep (wdata_rep),
    .ld_ext    (ld_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cap_store    <= 1'b0;
      cap_ld       <= 3'd0;
      cap_off      <= 2'd0;
      cnt          <= '0;
      ld_data      <= 32'h0;
      ld_valid     <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_be       <= 4'h0;
      mem_wdata    <= 32'h0;
    end else begin
      ld_valid     <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (lsu_start) begin
            cap_store <= is_store;
            cap_ld    <= ld_type;
            cap_off   <= addr[1:0];
            cnt       <= '0;
            if (lsu_misaligned(is_store, st_size, ld_type, addr[1:0])) begin
              err_misalign <= 1'b1;
              state        <= S_DONE;
            end else if (is_store && st_size == ST_NONE) begin
              state <= S_DONE;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= is_store ? be_st : 4'b1111;
              mem_wdata <= is_store ? wdata_rep : 32'h0;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt || timed_out) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
          end
          // A grant arriving on the final cycle still wins over the timeout.
          if (mem_gnt) begin
            cnt   <= cnt + 1'b1;
            state <= cap_store ? S_DONE : S_WAIT;
          end else if (timed_out) begin
            err_timeout <= 1'b1;
            ld_data     <= 32'h0;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            ld_data  <= ld_ext;
            ld_valid <= 1'b1;
            state    <= S_DONE;
          end else if (timed_out) begin
            err_timeout <= 1'b1;
            ld_data     <= 32'h0;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
